// File: rtl/uart_pkg.sv
// Shared types and FSM encodings for the UART transmit arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

    localparam int UART_WORD_W = 8;

    typedef logic [UART_WORD_W-1:0] word_t;

    // Arbiter FSM encodings, kept as plain constants for legacy tools.
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] OWN  = 1'b1;

endpackage

// File: rtl/uart_rr_pick.sv
// Round-robin picker: first requester set after i_last, wrapping modulo N.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the pick is consumed.
module uart_rr_pick
    import uart_pkg::*;
#(
    parameter int N  = 3,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_last,
    output logic [N-1:0]  o_onehot,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);

    logic [IW-1:0]  w_start;
    logic [2*N-1:0] w_dbl;
    logic [N-1:0]   w_rot;
    logic [IW-1:0]  w_off;
    logic [IW:0]    w_sum;

    // Search begins one past the previous owner, wrapping back to 0.
    always_comb begin
        if (i_last == IW'(N - 1)) w_start = '0;
        else                      w_start = i_last + IW'(1);
    end

    // Rotate so the highest-priority requester lands in bit 0.
    always_comb begin
        w_dbl = {i_req, i_req};
        w_rot = w_dbl[w_start +: N];
    end

    // Priority-encode the rotated vector (lowest set bit wins).
    always_comb begin
        w_off = '0;
        o_any = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_off = IW'(k);
                o_any = 1'b1;
            end
        end
    end

    // Un-rotate the offset back into an absolute requester index.
    always_comb begin
        w_sum    = {1'b0, w_start} + {1'b0, w_off};
        o_idx    = (int'(w_sum) >= N) ? IW'(int'(w_sum) - N) : w_sum[IW-1:0];
        o_onehot = '0;
        if (o_any) o_onehot[o_idx] = 1'b1;
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin sharing of one uart_tx among NUM_REQ clients.
// Latency: one cycle from req_valid to grant; words then pass through combinationally.
// Backpressure: tx_ready is routed to the owner's req_ready only; others see 0.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ       = 3,
    parameter int BITS_PER_WORD = 8,
    parameter int MAX_PKT       = 16
) (
    input  logic                             clk,
    input  logic                             rstn,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ*BITS_PER_WORD-1:0] req_data,
    input  logic [NUM_REQ-1:0]               req_last,
    output logic [NUM_REQ-1:0]               req_ready,
    output logic                             tx_valid,
    output logic [BITS_PER_WORD-1:0]         tx_data,
    input  logic                             tx_ready,
    output logic [NUM_REQ-1:0]               grant,
    output logic                             busy
);

    localparam int            IW       = $clog2(NUM_REQ);
    localparam int            CW       = $clog2(MAX_PKT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(MAX_PKT - 1);

    logic [0:0]               r_state;
    logic [NUM_REQ-1:0]       r_grant;
    logic [IW-1:0]            r_gidx;
    logic [IW-1:0]            r_last_grant;
    logic [CW-1:0]            r_cnt;

    logic [NUM_REQ-1:0]       w_pick_oh;
    logic [IW-1:0]            w_pick_idx;
    logic                     w_pick_any;
    logic [BITS_PER_WORD-1:0] w_data;
    logic                     w_xfer;
    logic                     w_own_last;
    logic                     w_release;

    uart_rr_pick #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_pick (
        .i_req    (req_valid),
        .i_last   (r_last_grant),
        .o_onehot (w_pick_oh),
        .o_idx    (w_pick_idx),
        .o_any    (w_pick_any)
    );

    // Owner's data slice; the grant is zero when idle, so this reads zero then.
    always_comb begin
        w_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_grant[i]) w_data = w_data | req_data[i*BITS_PER_WORD +: BITS_PER_WORD];
        end
    end

    // Stream steering, all derived from the registered one-hot grant.
    always_comb begin
        tx_valid   = |(req_valid & r_grant);
        tx_data    = w_data;
        req_ready  = tx_ready ? r_grant : '0;
        w_xfer     = tx_valid && tx_ready;
        w_own_last = |(req_last & r_grant);
        w_release  = w_xfer && (w_own_last || (r_cnt == CNT_LAST));
        grant      = r_grant;
        busy       = (r_state == OWN);
    end

    // Grant FSM: pick in IDLE, hold in OWN until a last word or the packet cap.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state      <= IDLE;
            r_grant      <= '0;
            r_gidx       <= '0;
            r_last_grant <= IW'(NUM_REQ - 1);
            r_cnt        <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pick_any) begin
                        r_state <= OWN;
                        r_grant <= w_pick_oh;
                        r_gidx  <= w_pick_idx;
                        r_cnt   <= '0;
                    end
                end
                default: begin
                    if (w_release) begin
                        r_state      <= IDLE;
                        r_grant      <= '0;
                        r_last_grant <= r_gidx;
                        r_cnt        <= '0;
                    end else if (w_xfer) begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
            endcase
        end
    end

    // Invariants: single owner, single ready, no valid without ownership.
    a_grant_onehot0: assert property (@(posedge clk) disable iff (!rstn) $onehot0(grant));
    a_ready_onehot0: assert property (@(posedge clk) disable iff (!rstn) $onehot0(req_ready));
    a_valid_busy:    assert property (@(posedge clk) disable iff (!rstn) tx_valid |-> busy);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;
    import uart_pkg::*;

    localparam int NR = 3;
    localparam int BW = 8;
    localparam int MP = 4;

    logic            clk = 1'b0;
    logic            rstn;
    logic [NR-1:0]   req_valid;
    logic [NR*BW-1:0] req_data;
    logic [NR-1:0]   req_last;
    logic [NR-1:0]   req_ready;
    logic            tx_valid;
    logic [BW-1:0]   tx_data;
    logic            tx_ready;
    logic [NR-1:0]   grant;
    logic            busy;

    int total = 0;
    int bad   = 0;

    uart_tx_arbiter #(
        .NUM_REQ       (NR),
        .BITS_PER_WORD (BW),
        .MAX_PKT       (MP)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready),
        .grant     (grant),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  v;
        logic [23:0] d;
        logic [2:0]  l;
        logic        rdy;
        logic [2:0]  e_gnt;
        logic        e_busy;
        logic        e_txv;
        logic [7:0]  e_txd;
        logic [2:0]  e_rrdy;
    } vec_t;

    localparam int NV = 28;
    vec_t tbl [NV];

    // stream-run state
    logic [7:0] sd [3][8];
    int         slen [3];
    int         sptr [3];
    int         sstart [3];
    logic [7:0] log_d [16];
    logic [2:0] log_g [16];
    int         nlog;

    function automatic vec_t mk(input logic [2:0] v, input logic [23:0] d, input logic [2:0] l,
                                input logic r, input logic [2:0] g, input logic b, input logic tv,
                                input logic [7:0] td, input logic [2:0] rr);
        vec_t x;
        x.v = v; x.d = d; x.l = l; x.rdy = r;
        x.e_gnt = g; x.e_busy = b; x.e_txv = tv; x.e_txd = td; x.e_rrdy = rr;
        return x;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] snap();
        return {16'h0, grant, busy, tx_valid, tx_data, req_ready};
    endfunction

    function automatic logic [31:0] pack(input logic [2:0] g, input logic b, input logic tv,
                                         input logic [7:0] td, input logic [2:0] rr);
        return {16'h0, g, b, tv, td, rr};
    endfunction

    task automatic drive(input logic [2:0] v, input logic [23:0] d, input logic [2:0] l, input logic r);
        req_valid = v;
        req_data  = d;
        req_last  = l;
        tx_ready  = r;
    endtask

    task automatic run_stream(input string nm);
        bit done;
        int cyc;
        done = 0;
        nlog = 0;
        for (int r = 0; r < 3; r++) sptr[r] = 0;
        for (cyc = 0; cyc < 300 && !done; cyc++) begin
            req_valid = '0;
            req_last  = '0;
            req_data  = '0;
            for (int r = 0; r < 3; r++) begin
                if (cyc >= sstart[r] && sptr[r] < slen[r]) begin
                    req_valid[r]          = 1'b1;
                    req_data[r*BW +: BW]  = sd[r][sptr[r]];
                    req_last[r]           = (sptr[r] == slen[r] - 1);
                end
            end
            tx_ready = ((cyc % 3) != 2);
            #1;
            if (tx_valid && tx_ready && nlog < 16) begin
                log_d[nlog] = tx_data;
                log_g[nlog] = grant;
                nlog++;
            end
            for (int r = 0; r < 3; r++) begin
                if (req_valid[r] && req_ready[r]) sptr[r]++;
            end
            done = (sptr[0] == slen[0]) && (sptr[1] == slen[1]) && (sptr[2] == slen[2]);
            @(negedge clk);
        end
        drive(3'b000, 24'h0, 3'b000, 1'b1);
        if (!done) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got unfinished stream want all words sent", nm);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] act;
        // rows: inputs | expected {grant,busy,tx_valid,tx_data,req_ready}
        tbl[0]  = mk(3'b000, 24'h000000, 3'b000, 1, 3'b000, 0, 0, 8'h00, 3'b000);
        tbl[1]  = mk(3'b111, 24'h332211, 3'b111, 1, 3'b000, 0, 0, 8'h00, 3'b000);
        tbl[2]  = mk(3'b111, 24'h332211, 3'b111, 1, 3'b001, 1, 1, 8'h11, 3'b001);
        tbl[3]  = mk(3'b110, 24'h332211, 3'b111, 1, 3'b000, 0, 0, 8'h00, 3'b000);
        tbl[4]  = mk(3'b110, 24'h332211, 3'b111, 1, 3'b010, 1, 1, 8'h22, 3'b010);
        tbl[5]  = mk(3'b100, 24'h332211, 3'b111, 1, 3'b000, 0, 0, 8'h00, 3'b000);
        tbl[6]  = mk(3'b100, 24'h332211, 3'b111, 1, 3'b100, 1, 1, 8'h33, 3'b100);
        tbl[7]  = mk(3'b000, 24'h000000, 3'b000, 1, 3'b000, 0, 0, 8'h00, 3'b000);
        tbl[8]  = mk(3'b001, 24'h0000A5, 3'b000, 1, 3'b000, 0, 0, 8'h00, 3'b000);
        tbl[9]  = mk(3'b001, 24'h0000A5, 3'b000, 1, 3'b001, 1, 1, 8'hA5, 3'b001);
        tbl[10] = mk(3'b001, 24'h00003C, 3'b001, 1, 3'b001, 1, 1, 8'h3C, 3'b001);
        tbl[11] = mk(3'b000, 24'h000000, 3'b000, 1, 3'b000, 0, 0, 8'h00, 3'b000);
        tbl[12] = mk(3'b010, 24'h004400, 3'b010, 0, 3'b000, 0, 0, 8'h00, 3'b000);
        tbl[13] = mk(3'b010, 24'h004400, 3'b010, 0, 3'b010, 1, 1, 8'h44, 3'b000);
        tbl[14] = mk(3'b010, 24'h004400, 3'b010, 1, 3'b010, 1, 1, 8'h44, 3'b010);
        tbl[15] = mk(3'b000, 24'h000000, 3'b000, 1, 3'b000, 0, 0, 8'h00, 3'b000);
        tbl[16] = mk(3'b100, 24'h550000, 3'b100, 1, 3'b000, 0, 0, 8'h00, 3'b000);
        tbl[17] = mk(3'b100, 24'h550000, 3'b100, 1, 3'b100, 1, 1, 8'h55, 3'b100);
        tbl[18] = mk(3'b101, 24'h660077, 3'b101, 1, 3'b000, 0, 0, 8'h00, 3'b000);
        tbl[19] = mk(3'b101, 24'h660077, 3'b101, 1, 3'b001, 1, 1, 8'h77, 3'b001);
        tbl[20] = mk(3'b100, 24'h660077, 3'b101, 1, 3'b000, 0, 0, 8'h00, 3'b000);
        tbl[21] = mk(3'b100, 24'h660077, 3'b101, 1, 3'b100, 1, 1, 8'h66, 3'b100);
        tbl[22] = mk(3'b000, 24'h000000, 3'b000, 1, 3'b000, 0, 0, 8'h00, 3'b000);
        tbl[23] = mk(3'b110, 24'h889900, 3'b110, 1, 3'b000, 0, 0, 8'h00, 3'b000);
        tbl[24] = mk(3'b110, 24'h889900, 3'b110, 1, 3'b010, 1, 1, 8'h99, 3'b010);
        tbl[25] = mk(3'b100, 24'h889900, 3'b110, 1, 3'b000, 0, 0, 8'h00, 3'b000);
        tbl[26] = mk(3'b100, 24'h889900, 3'b110, 1, 3'b100, 1, 1, 8'h88, 3'b100);
        tbl[27] = mk(3'b000, 24'h000000, 3'b000, 1, 3'b000, 0, 0, 8'h00, 3'b000);

        // reset state, even with requests pending
        rstn = 1'b0;
        drive(3'b111, 24'h332211, 3'b111, 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("reset_state", snap(), pack(3'b000, 0, 0, 8'h00, 3'b000));
        drive(3'b000, 24'h0, 3'b000, 1'b1);
        @(negedge clk);
        rstn = 1'b1;

        // single packet, contention order, backpressure, fairness wrap
        for (int i = 0; i < NV; i++) begin
            drive(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].rdy);
            #1;
            chk($sformatf("row%0d", i), snap(),
                pack(tbl[i].e_gnt, tbl[i].e_busy, tbl[i].e_txv, tbl[i].e_txd, tbl[i].e_rrdy));
            @(negedge clk);
        end

        // packet cap: req1 sends 6 words, req0 joins and cuts in after word 4
        for (int w = 0; w < 6; w++) sd[1][w] = 8'(w + 1);
        sd[0][0] = 8'hE0;
        slen[0] = 1; sstart[0] = 2;
        slen[1] = 6; sstart[1] = 0;
        slen[2] = 0; sstart[2] = 0;
        run_stream("maxpkt");
        begin
            logic [7:0] ed [7];
            logic [2:0] eg [7];
            ed = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hE0, 8'h05, 8'h06};
            eg = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b001, 3'b010, 3'b010};
            chk("maxpkt_count", 32'(nlog), 32'd7);
            for (int k = 0; k < 7; k++)
                chk($sformatf("maxpkt_w%0d", k), {21'h0, log_g[k], log_d[k]}, {21'h0, eg[k], ed[k]});
        end

        // owner stall: req0 drops valid mid-packet while req1 waits
        drive(3'b001, 24'h0000C1, 3'b000, 1'b1);
        #1;
        chk("stall_idle", snap(), pack(3'b000, 0, 0, 8'h00, 3'b000));
        @(negedge clk);
        #1;
        chk("stall_first", snap(), pack(3'b001, 1, 1, 8'hC1, 3'b001));
        @(negedge clk);
        drive(3'b010, 24'h00D100, 3'b010, 1'b1);
        act = '0;
        for (int c = 0; c < 50; c++) begin
            #1;
            act = {16'h0, grant, busy, tx_valid, 8'h00, req_ready};
            @(negedge clk);
            if (act != pack(3'b001, 1, 0, 8'h00, 3'b001)) break;
        end
        chk("stall_hold", act, pack(3'b001, 1, 0, 8'h00, 3'b001));
        drive(3'b011, 24'h00D1C2, 3'b011, 1'b1);
        #1;
        chk("stall_resume", snap(), pack(3'b001, 1, 1, 8'hC2, 3'b001));
        @(negedge clk);
        drive(3'b010, 24'h00D100, 3'b010, 1'b1);
        #1;
        chk("stall_gap", snap(), pack(3'b000, 0, 0, 8'h00, 3'b000));
        @(negedge clk);
        #1;
        chk("stall_next", snap(), pack(3'b010, 1, 1, 8'hD1, 3'b010));
        @(negedge clk);

        // reset in the middle of req2's packet
        drive(3'b100, 24'hB10000, 3'b000, 1'b1);
        #1;
        chk("rst_idle", snap(), pack(3'b000, 0, 0, 8'h00, 3'b000));
        @(negedge clk);
        #1;
        chk("rst_w1", snap(), pack(3'b100, 1, 1, 8'hB1, 3'b100));
        @(negedge clk);
        drive(3'b100, 24'hB20000, 3'b000, 1'b1);
        #1;
        chk("rst_w2", snap(), pack(3'b100, 1, 1, 8'hB2, 3'b100));
        rstn = 1'b0;
        #1;
        chk("rst_async", snap(), pack(3'b000, 0, 0, 8'h00, 3'b000));
        @(negedge clk);
        drive(3'b101, 24'hB200F0, 3'b101, 1'b1);
        rstn = 1'b1;
        #1;
        chk("rst_after", snap(), pack(3'b000, 0, 0, 8'h00, 3'b000));
        @(negedge clk);
        #1;
        chk("rst_regrant", snap(), pack(3'b001, 1, 1, 8'hF0, 3'b001));
        @(negedge clk);
        drive(3'b000, 24'h0, 3'b000, 1'b1);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
